// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: FSM state encoding, counter
// widths and the write-back request bundle seen by the controller.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INT_WAIT = 2'd1,
    S_FLUSH    = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  localparam int TRAP_CNT_W  = 16;
  localparam int WAIT_CNT_W  = 8;   // covers WAIT_MAX up to 255
  localparam int FLUSH_CNT_W = 3;   // covers FLUSH_CYCLES up to 7

  // What WB presents to the controller each cycle.
  typedef struct packed {
    logic        valid;
    logic        exc;
    logic [31:0] ret_addr;
  } wb_req_t;

endpackage

// File: rtl/trap_ctrl_sat_counter.sv
// sat_counter: up-counter that saturates at MAX.
//  clk_i/rst_i : clock, async active-low reset
//  clr_i       : synchronous clear to 0 (wins over en_i)
//  en_i        : count up by one unless already at MAX
//  at_max_o    : count == MAX
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic at_max_o
);

  logic [WIDTH-1:0] cnt_q;

  assign at_max_o = (cnt_q == WIDTH'(MAX));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 cnt_q <= '0;
    else if (clr_i)             cnt_q <= '0;
    else if (en_i && !at_max_o) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences trap entry/return beside the write-back stage.
// A WB exception/xret, or a pending interrupt attached to the next retiring
// instruction, becomes a FLUSH_CYCLES flush of IF/ID/EX/MEM followed by a
// single-cycle PC redirect to the target WB supplied at acceptance.
//  clk_i, rst_i         : clock, async active-low reset
//  wb_valid_i           : valid instruction in WB
//  exc_taken_i          : WB takes its own exception / xret this cycle
//  exc_ret_addr_i       : trap vector / mepc target from WB CSR file
//  int_pending_i        : enabled interrupt pending (level)
//  pipe_empty_i         : nothing valid in ID/EX/MEM
//  int_take_o           : WB instr is the interrupted one (comb)
//  stall_if_o, flush_o  : fetch hold / pipeline kill
//  redirect_o, redirect_pc_o : PC load strobe and target
//  trap_count_o         : traps accepted since reset (wraps)
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int WAIT_MAX     = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic        exc_taken_i,
  input  logic [31:0] exc_ret_addr_i,
  input  logic        int_pending_i,
  input  logic        pipe_empty_i,
  output logic        int_take_o,
  output logic        stall_if_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] trap_count_o
);

  wb_req_t wb;
  assign wb = '{valid: wb_valid_i, exc: exc_taken_i, ret_addr: exc_ret_addr_i};

  state_e                state_q, state_d;
  logic [31:0]           target_q;
  logic [31:0]           redirect_pc_q;
  logic [TRAP_CNT_W-1:0] trap_cnt_q;
  logic                  rel_done_q;   // empty-pipe fetch release already spent
  logic                  accept;
  logic                  release_fetch;
  logic                  wait_at_max;
  logic                  flush_at_max;

  // Wait counter runs only while in INT_WAIT, held at 0 elsewhere so it
  // starts from zero on every entry.
  sat_counter #(.WIDTH(WAIT_CNT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q != S_INT_WAIT),
    .en_i     (state_q == S_INT_WAIT),
    .at_max_o (wait_at_max)
  );

  // Flush counter counts flush cycles 0..FLUSH_CYCLES-1; at_max marks the
  // last one.
  sat_counter #(.WIDTH(FLUSH_CNT_W), .MAX(FLUSH_CYCLES - 1)) u_flush_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q != S_FLUSH),
    .en_i     (state_q == S_FLUSH),
    .at_max_o (flush_at_max)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    release_fetch = 1'b0;
    int_take_o    = 1'b0;
    stall_if_o    = 1'b0;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb.valid && wb.exc) begin
          accept  = 1'b1;
          state_d = S_FLUSH;
        end else if (int_pending_i) begin
          state_d = S_INT_WAIT;
        end
      end
      S_INT_WAIT: begin
        stall_if_o = 1'b1;
        if (wb.valid && wb.exc) begin
          // WB's own exception wins; the interrupt stays pending.
          accept  = 1'b1;
          state_d = S_FLUSH;
        end else if (!int_pending_i) begin
          state_d = S_IDLE;
        end else if (wb.valid) begin
          // Interrupt rides on this instr; WB supplies the vector on
          // exc_ret_addr_i in the same cycle. exc_taken_i must only reflect
          // WB's own exceptions, otherwise this path would loop.
          int_take_o = 1'b1;
          accept     = 1'b1;
          state_d    = S_FLUSH;
        end else if (wait_at_max && pipe_empty_i && !rel_done_q) begin
          // Nothing will ever retire: let exactly one instr in.
          stall_if_o    = 1'b0;
          release_fetch = 1'b1;
        end
      end
      S_FLUSH: begin
        flush_o    = 1'b1;
        stall_if_o = 1'b1;
        if (flush_at_max) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      redirect_pc_q <= '0;
      trap_cnt_q    <= '0;
      rel_done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        target_q   <= wb.ret_addr;
        trap_cnt_q <= trap_cnt_q + 1'b1;
      end
      // Output PC only moves when the redirect is issued.
      if (state_q == S_FLUSH && state_d == S_REDIRECT) redirect_pc_q <= target_q;
      rel_done_q <= (state_q == S_INT_WAIT) && (rel_done_q || release_fetch);
    end
  end

  assign redirect_pc_o = redirect_pc_q;
  assign trap_count_o  = trap_cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i, exc_taken_i, int_pending_i, pipe_empty_i;
  logic [31:0] exc_ret_addr_i;
  logic        int_take_o, stall_if_o, flush_o, redirect_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] trap_count_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  trap_ctrl #(.FLUSH_CYCLES(2), .WAIT_MAX(15)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wb_valid_i     (wb_valid_i),
    .exc_taken_i    (exc_taken_i),
    .exc_ret_addr_i (exc_ret_addr_i),
    .int_pending_i  (int_pending_i),
    .pipe_empty_i   (pipe_empty_i),
    .int_take_o     (int_take_o),
    .stall_if_o     (stall_if_o),
    .flush_o        (flush_o),
    .redirect_o     (redirect_o),
    .redirect_pc_o  (redirect_pc_o),
    .trap_count_o   (trap_count_o)
  );

  // ctl = {int_take, stall_if, flush, redirect}
  typedef struct {
    logic        wb, exc;
    logic [31:0] addr;
    logic        pend, empty;
    logic [3:0]  ctl;
    logic [31:0] pc;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic drive(input logic wb, exc, input logic [31:0] addr, input logic pend, empty);
    wb_valid_i = wb; exc_taken_i = exc; exc_ret_addr_i = addr;
    int_pending_i = pend; pipe_empty_i = empty;
  endtask

  function automatic logic [51:0] outs();
    return {int_take_o, stall_if_o, flush_o, redirect_o, redirect_pc_o, trap_count_o};
  endfunction

  function automatic logic [3:0] ctl();
    return {int_take_o, stall_if_o, flush_o, redirect_o};
  endfunction

  task automatic chk(input string name, input logic [51:0] act, input logic [51:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 chk("reset", outs(), 52'd0);
    @(negedge clk_i);

    // exception: flush x2, redirect to 0x100
    tv.push_back('{1, 1, 32'h100,  0, 0, 4'b0000, 32'h0,   16'd0});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0110, 32'h0,   16'd1});
    tv.push_back('{1, 1, 32'hDEAD, 0, 0, 4'b0110, 32'h0,   16'd1});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0001, 32'h100, 16'd1});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0000, 32'h100, 16'd1});
    // interrupt taken on instr retiring 3 cycles after pending
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0000, 32'h100, 16'd1});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0100, 32'h100, 16'd1});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0100, 32'h100, 16'd1});
    tv.push_back('{1, 0, 32'h200,  1, 0, 4'b1100, 32'h100, 16'd1});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0110, 32'h100, 16'd2});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0110, 32'h100, 16'd2});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0001, 32'h200, 16'd2});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0000, 32'h200, 16'd2});
    // interrupt withdrawn while waiting
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0000, 32'h200, 16'd2});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0100, 32'h200, 16'd2});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0100, 32'h200, 16'd2});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0100, 32'h200, 16'd2});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0000, 32'h200, 16'd2});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0000, 32'h200, 16'd2});
    // exception and interrupt together: exception first, then INT_WAIT
    tv.push_back('{1, 1, 32'h300,  1, 0, 4'b0000, 32'h200, 16'd2});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0110, 32'h200, 16'd3});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0110, 32'h200, 16'd3});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0001, 32'h300, 16'd3});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0000, 32'h300, 16'd3});
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0100, 32'h300, 16'd3});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0100, 32'h300, 16'd3});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0000, 32'h300, 16'd3});
    // WB exception while waiting for interrupt: no int_take
    tv.push_back('{0, 0, 32'h0,    1, 0, 4'b0000, 32'h300, 16'd3});
    tv.push_back('{1, 1, 32'h400,  1, 0, 4'b0100, 32'h300, 16'd3});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0110, 32'h300, 16'd4});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0110, 32'h300, 16'd4});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0001, 32'h400, 16'd4});
    tv.push_back('{0, 0, 32'h0,    0, 0, 4'b0000, 32'h400, 16'd4});

    foreach (tv[i]) begin
      drive(tv[i].wb, tv[i].exc, tv[i].addr, tv[i].pend, tv[i].empty);
      #1 chk($sformatf("vec%0d", i), outs(), {tv[i].ctl, tv[i].pc, tv[i].cnt});
      @(negedge clk_i);
    end

    // empty pipe: 15 stalled cycles, one release at wait count 15, then stall again
    drive(0, 0, 0, 1, 1);
    #1 chk("empty_idle", {48'd0, ctl()}, {48'd0, 4'b0000});
    @(negedge clk_i);
    for (int i = 1; i <= 20; i++) begin
      #1 chk($sformatf("empty_wait%0d", i), {48'd0, ctl()},
             {48'd0, (i == 16) ? 4'b0000 : 4'b0100});
      @(negedge clk_i);
    end
    drive(1, 0, 32'h500, 1, 1);
    #1 chk("empty_take", {48'd0, ctl()}, {48'd0, 4'b1100});
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0);
    #1 chk("empty_fl1", outs(), {4'b0110, 32'h400, 16'd5});
    @(negedge clk_i);
    #1 chk("empty_fl2", outs(), {4'b0110, 32'h400, 16'd5});
    @(negedge clk_i);
    #1 chk("empty_redir", outs(), {4'b0001, 32'h500, 16'd5});
    @(negedge clk_i);

    // async reset in the middle of a flush
    drive(1, 1, 32'h600, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0);
    #1 chk("rst_pre", outs(), {4'b0110, 32'h500, 16'd6});
    #2 rst_i = 1'b0;
    #1 chk("rst_async", outs(), 52'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("rst_post%0d", i), outs(), 52'd0);
      @(negedge clk_i);
    end

    // trap counter wrap 0xFFFF -> 0
    force dut.trap_cnt_q = 16'hFFFF;
    #1 release dut.trap_cnt_q;
    #1 chk("wrap_pre", {36'd0, trap_count_o}, {36'd0, 16'hFFFF});
    @(negedge clk_i);
    drive(1, 1, 32'h700, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0);
    #1 chk("wrap_fl1", outs(), {4'b0110, 32'h0, 16'h0000});
    @(negedge clk_i);
    @(negedge clk_i);
    #1 chk("wrap_redir", outs(), {4'b0001, 32'h700, 16'h0000});
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
